// File: rtl/mesh_pkg.sv
// Shared mesh definitions: link retry controller state encoding.
package mesh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_ACK_FLUSH = 3'd2,
        ST_REPLAY    = 3'd3,
        ST_ERROR     = 3'd4
    } link_retry_state_t;

endpackage

// File: rtl/retry_timer.sv
// Ack-progress timeout countdown: load arms TIMEOUT enabled cycles, expired flags the last one.
// Latency: expired is combinational from the count; load always wins over expiry.
module retry_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (nreset) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(TIMEOUT - 1);
        end else if (enable && count != '0) begin
            count <= count - TW'(1);
        end
    end

    // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th enabled cycle.
    assign expired = enable && !load && (count == '0);

endmodule

// File: rtl/link_retry_ctrl.sv
// Link-layer retry controller: tracks unacked packets, retires acks, rewinds the replay buffer on nack/timeout.
// Latency: ack/ack_count registered 1 cycle after an accepted ack; nack asserted for the single REPLAY cycle.
module link_retry_ctrl
    import mesh_pkg::*;
#(
    parameter int SEQ_W       = 4,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRIES = 3
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             tx_fire,
    input  logic             rx_ack_valid,
    input  logic [SEQ_W-1:0] rx_ack_seq,
    input  logic             rx_nack_valid,
    input  logic [SEQ_W-1:0] rx_nack_seq,
    output logic             ack,
    output logic [SEQ_W-1:0] ack_count,
    output logic             nack,
    output logic [SEQ_W-1:0] tx_seq,
    output logic             tx_allow,
    output logic [SEQ_W:0]   outstanding,
    output logic             link_error
);
    localparam int             RW       = $clog2(MAX_RETRIES + 2);
    localparam logic [SEQ_W:0] FULL_CNT = {1'b0, {SEQ_W{1'b1}}};

    link_retry_state_t state, state_next;
    logic [SEQ_W-1:0]  ack_seq, ack_in_seq, delta;
    logic [SEQ_W:0]    outstanding_next;
    logic [RW-1:0]     retry_cnt;
    logic              live, fire, ack_in_vld, ack_take;
    logic              timer_load, timer_expired;

    assign tx_allow   = (state != ST_ERROR) && (outstanding != FULL_CNT);
    assign link_error = (state == ST_ERROR);
    // Gated by reset so a replay interrupted by reset never rewinds the buffer.
    assign nack       = (state == ST_REPLAY) && !nreset;

    always_comb begin
        live       = (state == ST_IDLE) || (state == ST_WAIT);
        fire       = live && tx_fire && tx_allow;
        // A nack carries an implicit cumulative ack and overrides a coincident ack.
        ack_in_seq = rx_nack_valid ? rx_nack_seq : rx_ack_seq;
        ack_in_vld = live && (rx_ack_valid || rx_nack_valid);
        delta      = ack_in_seq - ack_seq;
        ack_take   = ack_in_vld && (delta != '0) && ({1'b0, delta} <= outstanding);
        outstanding_next = outstanding + {{SEQ_W{1'b0}}, fire}
                         - (ack_take ? {1'b0, delta} : {(SEQ_W+1){1'b0}});
        timer_load = ((state == ST_IDLE) && fire) || ack_take || (state == ST_REPLAY);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (rx_nack_valid) begin
                    state_next = ack_take ? ST_ACK_FLUSH : ST_REPLAY;
                end else if (outstanding_next == '0) begin
                    state_next = ST_IDLE;
                end else if (state == ST_IDLE) begin
                    state_next = ST_WAIT;
                end else if (timer_expired) begin
                    state_next = ST_REPLAY;
                end
            end
            ST_ACK_FLUSH: state_next = ST_REPLAY;
            ST_REPLAY:    state_next = (int'(retry_cnt) >= MAX_RETRIES) ? ST_ERROR : ST_WAIT;
            ST_ERROR:     state_next = ST_ERROR;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state       <= ST_IDLE;
            tx_seq      <= '0;
            ack_seq     <= '0;
            outstanding <= '0;
            retry_cnt   <= '0;
            ack         <= 1'b0;
            ack_count   <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            ack         <= ack_take;
            ack_count   <= ack_take ? delta : '0;
            if (fire) begin
                tx_seq <= tx_seq + SEQ_W'(1);
            end
            if (ack_take) begin
                ack_seq   <= ack_seq + delta;
                retry_cnt <= '0;
            end else if (state == ST_REPLAY) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
        end
    end

    retry_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .nreset  (nreset),
        .load    (timer_load),
        .enable  (state == ST_WAIT),
        .expired (timer_expired)
    );

endmodule

// File: tb/tb_link_retry_ctrl.sv
// Scoreboard bench for link_retry_ctrl: stimulus queues expected ack/nack pulses, a negedge monitor checks them.
module tb_link_retry_ctrl;
    import mesh_pkg::*;

    localparam int SEQ_W       = 4;
    localparam int TIMEOUT     = 255;
    localparam int MAX_RETRIES = 3;

    typedef struct {
        bit       is_nack;
        int       count;
    } exp_t;

    logic             clk;
    logic             nreset;
    logic             tx_fire;
    logic             rx_ack_valid;
    logic [SEQ_W-1:0] rx_ack_seq;
    logic             rx_nack_valid;
    logic [SEQ_W-1:0] rx_nack_seq;
    logic             ack;
    logic [SEQ_W-1:0] ack_count;
    logic             nack;
    logic [SEQ_W-1:0] tx_seq;
    logic             tx_allow;
    logic [SEQ_W:0]   outstanding;
    logic             link_error;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    link_retry_ctrl #(
        .SEQ_W       (SEQ_W),
        .TIMEOUT     (TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .tx_fire       (tx_fire),
        .rx_ack_valid  (rx_ack_valid),
        .rx_ack_seq    (rx_ack_seq),
        .rx_nack_valid (rx_nack_valid),
        .rx_nack_seq   (rx_nack_seq),
        .ack           (ack),
        .ack_count     (ack_count),
        .nack          (nack),
        .tx_seq        (tx_seq),
        .tx_allow      (tx_allow),
        .outstanding   (outstanding),
        .link_error    (link_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every ack or nack pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (ack || nack) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: ack=%0d nack=%0d ack_count=%0d, none expected",
                         ack, nack, ack_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (ack != !mon_e.is_nack || nack != mon_e.is_nack ||
                    (ack && int'(ack_count) != mon_e.count)) begin
                    n_fail++;
                    $display("FAIL pulse: got ack=%0d nack=%0d ack_count=%0d, expected %s count=%0d",
                             ack, nack, ack_count, mon_e.is_nack ? "nack" : "ack", mon_e.count);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input bit is_nack, input int count);
        exp_t e;
        e.is_nack = is_nack;
        e.count   = count;
        exp_q.push_back(e);
    endtask

    task automatic fire_n(input int n);
        tx_fire = 1'b1;
        repeat (n) step();
        tx_fire = 1'b0;
    endtask

    task automatic do_ack(input logic [SEQ_W-1:0] s);
        rx_ack_valid = 1'b1;
        rx_ack_seq   = s;
        step();
        rx_ack_valid = 1'b0;
    endtask

    task automatic do_nack(input logic [SEQ_W-1:0] s);
        rx_nack_valid = 1'b1;
        rx_nack_seq   = s;
        step();
        rx_nack_valid = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b1;
        step();
        step();
        nreset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        nreset = 1'b1; tx_fire = 1'b0;
        rx_ack_valid = 1'b0; rx_ack_seq = '0;
        rx_nack_valid = 1'b0; rx_nack_seq = '0;
        step();
        step();
        check("rst_ack", int'(ack), 0);
        check("rst_nack", int'(nack), 0);
        check("rst_link_error", int'(link_error), 0);
        check("rst_tx_allow", int'(tx_allow), 1);
        check("rst_outstanding", int'(outstanding), 0);
        check("rst_tx_seq", int'(tx_seq), 0);
        nreset = 1'b0;

        // Three packets, cumulative ack of all three.
        fire_n(3);
        check("c1_outstanding_3", int'(outstanding), 3);
        expect_pulse(1'b0, 3);
        do_ack(4'd3);
        check("c1_ack_high", int'(ack), 1);
        check("c1_outstanding_0", int'(outstanding), 0);
        check("c1_state_idle", int'(dut.state), int'(ST_IDLE));

        // Fill to 15 outstanding, extra fire ignored, one ack reopens.
        do_reset();
        fire_n(15);
        check("c2_tx_allow_full", int'(tx_allow), 0);
        check("c2_outstanding_15", int'(outstanding), 15);
        fire_n(1);
        check("c2_tx_seq_held", int'(tx_seq), 15);
        check("c2_outstanding_held", int'(outstanding), 15);
        expect_pulse(1'b0, 1);
        do_ack(4'd1);
        check("c2_tx_allow_reopen", int'(tx_allow), 1);
        check("c2_outstanding_14", int'(outstanding), 14);

        // Nack with implicit ack of 2: ack pulse, then nack pulse.
        do_reset();
        fire_n(5);
        expect_pulse(1'b0, 2);
        expect_pulse(1'b1, 0);
        do_nack(4'd2);
        check("c3_state_flush", int'(dut.state), int'(ST_ACK_FLUSH));
        step();
        check("c3_nack_high", int'(nack), 1);
        check("c3_outstanding_3", int'(outstanding), 3);
        step();

        // Ack and nack together: nack sequence wins.
        do_reset();
        fire_n(4);
        expect_pulse(1'b0, 1);
        expect_pulse(1'b1, 0);
        rx_ack_valid = 1'b1; rx_ack_seq = 4'd3;
        do_nack(4'd1);
        rx_ack_valid = 1'b0;
        step();
        step();
        check("c4_outstanding_3", int'(outstanding), 3);

        // Fire and ack in the same cycle both take effect.
        do_reset();
        fire_n(3);
        expect_pulse(1'b0, 2);
        tx_fire = 1'b1;
        do_ack(4'd2);
        tx_fire = 1'b0;
        check("c5_outstanding_2", int'(outstanding), 2);
        check("c5_tx_seq_4", int'(tx_seq), 4);
        expect_pulse(1'b0, 2);
        do_ack(4'd4);
        check("c5_outstanding_0", int'(outstanding), 0);
        check("c5_state_idle", int'(dut.state), int'(ST_IDLE));

        // Sequence wrap: ack_seq 14 -> 2 retires 4; stale and over-range acks ignored.
        do_reset();
        fire_n(14);
        expect_pulse(1'b0, 14);
        do_ack(4'd14);
        check("c6_tx_seq_14", int'(tx_seq), 14);
        fire_n(4);
        check("c6_tx_seq_wrap", int'(tx_seq), 2);
        check("c6_outstanding_4", int'(outstanding), 4);
        expect_pulse(1'b0, 4);
        do_ack(4'd2);
        check("c6_outstanding_0", int'(outstanding), 0);
        do_ack(4'd14);
        check("c6_stale_no_ack", int'(ack), 0);
        check("c6_stale_outstanding", int'(outstanding), 0);
        fire_n(2);
        do_ack(4'd5);
        check("c6_overrange_outstanding", int'(outstanding), 2);

        // Reset during REPLAY aborts without a nack pulse.
        do_reset();
        fire_n(2);
        do_nack(4'd0);
        check("c7_state_replay", int'(dut.state), int'(ST_REPLAY));
        nreset = 1'b1;
        step();
        step();
        nreset = 1'b0;
        check("c7_outstanding_0", int'(outstanding), 0);
        check("c7_tx_seq_0", int'(tx_seq), 0);
        check("c7_state_idle", int'(dut.state), int'(ST_IDLE));

        // Timeouts: four replays, then sticky link error.
        do_reset();
        repeat (4) expect_pulse(1'b1, 0);
        fire_n(1);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (!nack && cyc < TIMEOUT + 10);
            check($sformatf("c8_timeout_latency_%0d", k), cyc, (k == 0) ? TIMEOUT : TIMEOUT + 1);
            check($sformatf("c8_no_error_yet_%0d", k), int'(link_error), 0);
        end
        step();
        check("c8_link_error", int'(link_error), 1);
        check("c8_tx_allow_0", int'(tx_allow), 0);
        do_ack(4'd1);
        do_nack(4'd1);
        fire_n(1);
        step();
        check("c8_error_outstanding", int'(outstanding), 1);
        check("c8_error_sticky", int'(link_error), 1);

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
